// File: rtl/keyb_led_tx.sv
// rtl/keyb_led_tx.sv - CH9350 keyboard LED command framer and UART 8N1 transmitter
module keyb_led_tx #(
    parameter int CLKS_PER_BIT = 312
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [2:0] i_leds,
    input  logic       i_send,
    output logic       o_txd,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [2:0]    byte_idx;
    logic [2:0]    bit_idx;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    frame_leds;
    logic [2:0]    sent_leds;
    logic          pending;
    logic [7:0]    cur_byte;
    logic          trigger;
    logic          bit_end;

    // Byte being serialised, selected from the frozen LED snapshot
    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            3'd0:    cur_byte = 8'h57;
            3'd1:    cur_byte = 8'hAB;
            3'd2:    cur_byte = 8'h12;
            3'd3:    cur_byte = {5'b0, frame_leds};
            3'd4:    cur_byte = 8'h12 + {5'b0, frame_leds};
            default: cur_byte = 8'h00;
        endcase
    end

    assign trigger = i_send || pending || (i_leds != sent_leds);
    assign bit_end = (cyc_cnt == CYC_LAST);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= S_IDLE;
            byte_idx   <= 3'd0;
            bit_idx    <= 3'd0;
            cyc_cnt    <= '0;
            frame_leds <= 3'd0;
            sent_leds  <= 3'd0;
            pending    <= 1'b0;
            o_txd      <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            // Requests arriving outside IDLE collapse into one pending frame
            if (state != S_IDLE && i_send) begin
                pending <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        frame_leds <= i_leds;
                        sent_leds  <= i_leds;
                        pending    <= 1'b0;
                        byte_idx   <= 3'd0;
                        cyc_cnt    <= '0;
                        state      <= S_START;
                        o_txd      <= 1'b0;
                        o_busy     <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_idx <= 3'd0;
                        o_txd   <= cur_byte[0];
                        state   <= S_DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            o_txd <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            o_txd   <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (byte_idx == 3'd4) begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            o_txd    <= 1'b0;
                            state    <= S_START;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keyb_led_tx.sv
// tb/tb_keyb_led_tx.sv - scoreboard bench for keyb_led_tx with a UART decoding monitor
module tb_keyb_led_tx;

    localparam int CLKS  = 16;
    localparam int FRAME = 50 * CLKS;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] leds = 3'b000;
    logic       send = 1'b0;
    logic       txd;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;
    int rx_bytes = 0;
    logic [7:0] exp_q[$];

    keyb_led_tx #(.CLKS_PER_BIT(CLKS)) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .i_leds(leds),
        .i_send(send),
        .o_txd (txd),
        .o_busy(busy),
        .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [7:0] ledb, input logic [7:0] csum);
        exp_q.push_back(8'h57);
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'h12);
        exp_q.push_back(ledb);
        exp_q.push_back(csum);
    endtask

    task automatic pulse_send();
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_timeout"}, int'(done === 1'b1), 1);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check({name, "_no_frame"}, int'(seen), 0);
    endtask

    // UART monitor: decodes bytes at mid-bit and compares against the expected queue
    initial begin
        int cnt;
        int k;
        bit active;
        logic [7:0] sh;
        logic [7:0] e;
        active = 1'b0;
        cnt = 0;
        sh = 8'h00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                active = 1'b0;
            end else if (!active) begin
                if (txd == 1'b0) begin
                    active = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt % CLKS == CLKS / 2) begin
                    k = cnt / CLKS;
                    if (k == 0) begin
                        check("start_bit", int'(txd), 0);
                    end else if (k <= 8) begin
                        sh[k-1] = txd;
                    end else begin
                        check("stop_bit", int'(txd), 1);
                        if (exp_q.size() == 0) begin
                            check("unexpected_byte", int'(sh), -1);
                        end else begin
                            e = exp_q.pop_front();
                            check("rx_byte", int'(sh), int'(e));
                        end
                        rx_bytes++;
                        active = 1'b0;
                    end
                end
            end
        end
    end

    // Frame timing monitor: busy length and single-cycle done
    initial begin
        int busy_len;
        bit done_prev;
        busy_len = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                busy_len = 0;
                done_prev = 1'b0;
            end else begin
                if (busy) begin
                    busy_len++;
                end else if (done) begin
                    check("busy_len", busy_len, FRAME);
                    check("done_single", int'(done_prev), 0);
                    busy_len = 0;
                end else begin
                    busy_len = 0;
                end
                done_prev = done;
            end
        end
    end

    initial begin
        int n;
        repeat (5) @(negedge clk);
        check("rst_txd", int'(txd), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rstn = 1'b1;
        expect_quiet("post_reset", 2000);

        // LED change 0 -> 010 triggers a frame, start bit one cycle after trigger edge
        push_frame(8'h02, 8'h14);
        leds = 3'b010;
        @(negedge clk);
        check("lat_txd", int'(txd), 0);
        check("lat_busy", int'(busy), 1);
        wait_done("f1");
        expect_quiet("f1_after", 50);

        // Forced resend with unchanged LEDs
        push_frame(8'h02, 8'h14);
        pulse_send();
        wait_done("f2");
        expect_quiet("f2_after", 300);

        // LED change and two send pulses during a frame -> exactly one extra frame
        push_frame(8'h02, 8'h14);
        push_frame(8'h05, 8'h17);
        pulse_send();
        repeat (100) @(negedge clk);
        leds = 3'b101;
        pulse_send();
        repeat (50) @(negedge clk);
        pulse_send();
        wait_done("f3");
        @(negedge clk);
        check("b2b_idle_txd", int'(txd), 1);
        @(negedge clk);
        check("b2b_start_txd", int'(txd), 0);
        check("b2b_start_busy", int'(busy), 1);
        wait_done("f4");
        expect_quiet("f4_after", 300);

        // Simultaneous send and LED change in IDLE -> one frame
        push_frame(8'h07, 8'h19);
        @(negedge clk);
        leds = 3'b111;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("sim_busy", int'(busy), 1);
        wait_done("f5");
        expect_quiet("f5_after", 300);

        // Reset during byte 2, then a fresh frame after release
        push_frame(8'h01, 8'h13);
        n = rx_bytes;
        leds = 3'b001;
        for (int i = 0; i < 2 * FRAME && rx_bytes < n + 2; i++) @(negedge clk);
        check("byte2_reach", rx_bytes - n, 2);
        for (int i = 0; i < 4 * CLKS && txd != 1'b0; i++) @(negedge clk);
        check("byte2_start_low", int'(txd), 0);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_txd", int'(txd), 1);
        check("midrst_busy", int'(busy), 0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        push_frame(8'h01, 8'h13);
        rstn = 1'b1;
        wait_done("f6");
        expect_quiet("f6_after", 300);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
